mac_tx_fcs_insert: RTL and testbench

MAC_TX_FCS_INSERT -- requirements
Module: mac_tx_fcs_insert

---
 rtl/mac_tx_fcs_insert.sv | 160 ++++++++++++++++
 tb/tb_mac_tx_fcs_insert.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_fcs_insert.sv
// Appends the Ethernet FCS to a 32-bit AXI-Stream frame, optionally zero-padding
// short frames first. The output side is a single register stage.
module mac_tx_fcs_insert #(
  parameter int DATA_WIDTH      = 32,
  parameter int ENABLE_PAD      = 1,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   i_s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] i_s_axis_tkeep,
  input  logic                    i_s_axis_tvalid,
  input  logic                    i_s_axis_tlast,
  output logic                    o_s_axis_tready,
  output logic [DATA_WIDTH-1:0]   o_m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] o_m_axis_tkeep,
  output logic                    o_m_axis_tvalid,
  output logic                    o_m_axis_tlast,
  input  logic                    i_m_axis_tready
);
  typedef enum logic [1:0] {DATA, PAD, FCS} state_t;

  state_t      state;
  logic [31:0] crc_state;
  logic [15:0] byte_count;
  logic [2:0]  spill;
  logic        run;

  logic        load, accept, pad_now, count_done;
  logic [2:0]  last_k, eff_k;
  logic [16:0] count_k;
  logic [15:0] count_inc;
  logic [31:0] lane_mask, masked_data, crc_data, crc_zero, fcs_now, fcs_hold;
  logic [31:0] merged_data, spill_data;
  logic [3:0]  spill_keep;

  function automatic logic [31:0] crc32_bytes(input logic [31:0] crc,
                                              input logic [31:0] data,
                                              input logic [2:0]  nbytes);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        c = c ^ {24'h0, data[8*b +: 8]};
        for (int i = 0; i < 8; i++)
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  assign load            = !o_m_axis_tvalid || i_m_axis_tready;
  assign o_s_axis_tready = run && (state == DATA) && load;
  assign accept          = o_s_axis_tready && i_s_axis_tvalid;

  always_comb begin
    // An all-zero keep on a last beat still means a full word.
    if (i_s_axis_tkeep[3])      last_k = 3'd4;
    else if (i_s_axis_tkeep[2]) last_k = 3'd3;
    else if (i_s_axis_tkeep[1]) last_k = 3'd2;
    else if (i_s_axis_tkeep[0]) last_k = 3'd1;
    else                        last_k = 3'd4;
    eff_k = i_s_axis_tlast ? last_k : 3'd4;

    case (eff_k)
      3'd1:    lane_mask = 32'h0000_00FF;
      3'd2:    lane_mask = 32'h0000_FFFF;
      3'd3:    lane_mask = 32'h00FF_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    masked_data = i_s_axis_tdata[31:0] & lane_mask;

    count_k    = {1'b0, byte_count} + {14'h0, eff_k};
    pad_now    = (ENABLE_PAD != 0) && i_s_axis_tlast &&
                 (count_k < 17'(MIN_FRAME_BYTES));
    count_inc  = (byte_count > 16'hFFFB) ? 16'hFFFF : byte_count + 16'd4;
    count_done = ({1'b0, count_inc} >= 17'(MIN_FRAME_BYTES));

    crc_data = crc32_bytes(crc_state, masked_data, pad_now ? 3'd4 : eff_k);
    crc_zero = crc32_bytes(crc_state, 32'h0, 3'd4);
    fcs_now  = ~crc_data;
    fcs_hold = ~crc_state;

    // Short last beat: the leading FCS bytes fill the free upper lanes.
    case (eff_k)
      3'd1:    merged_data = {fcs_now[23:0], i_s_axis_tdata[7:0]};
      3'd2:    merged_data = {fcs_now[15:0], i_s_axis_tdata[15:0]};
      3'd3:    merged_data = {fcs_now[7:0],  i_s_axis_tdata[23:0]};
      default: merged_data = i_s_axis_tdata[31:0];
    endcase

    case (spill)
      3'd1:    begin spill_data = {24'h0, fcs_hold[31:24]}; spill_keep = 4'b0001; end
      3'd2:    begin spill_data = {16'h0, fcs_hold[31:16]}; spill_keep = 4'b0011; end
      3'd3:    begin spill_data = {8'h0,  fcs_hold[31:8]};  spill_keep = 4'b0111; end
      default: begin spill_data = fcs_hold;                 spill_keep = 4'b1111; end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= DATA;
      crc_state       <= 32'hFFFF_FFFF;
      byte_count      <= '0;
      spill           <= 3'd0;
      run             <= 1'b0;
      o_m_axis_tvalid <= 1'b0;
      o_m_axis_tlast  <= 1'b0;
      o_m_axis_tdata  <= '0;
      o_m_axis_tkeep  <= '0;
    end else begin
      run <= 1'b1;
      if (load) begin
        case (state)
          DATA: begin
            o_m_axis_tvalid <= accept;
            o_m_axis_tlast  <= 1'b0;
            if (accept) begin
              o_m_axis_tdata <= pad_now ? masked_data : merged_data;
              o_m_axis_tkeep <= 4'hF;
              crc_state      <= crc_data;
              byte_count     <= count_inc;
              if (i_s_axis_tlast) begin
                if (pad_now) begin
                  spill <= 3'd4;
                  state <= count_done ? FCS : PAD;
                end else begin
                  spill <= eff_k;
                  state <= FCS;
                end
              end
            end
          end
          PAD: begin
            o_m_axis_tvalid <= 1'b1;
            o_m_axis_tlast  <= 1'b0;
            o_m_axis_tdata  <= '0;
            o_m_axis_tkeep  <= 4'hF;
            crc_state       <= crc_zero;
            byte_count      <= count_inc;
            if (count_done) begin
              spill <= 3'd4;
              state <= FCS;
            end
          end
          FCS: begin
            o_m_axis_tvalid <= 1'b1;
            o_m_axis_tlast  <= 1'b1;
            o_m_axis_tdata  <= spill_data;
            o_m_axis_tkeep  <= spill_keep;
            crc_state       <= 32'hFFFF_FFFF;
            byte_count      <= '0;
            state           <= DATA;
          end
          default: state <= DATA;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_tx_fcs_insert.sv
// Bench for mac_tx_fcs_insert: one unpadded and one padded instance, driven in turn
// and compared against a table-driven CRC/byte-stream reference model.
module tb_mac_tx_fcs_insert;
  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic s_valid = 1'b0, s_last = 1'b0, sel = 1'b0, m_tready = 1'b1;
  logic s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1;
  logic [31:0] m_data0, m_data1;
  logic [3:0]  m_keep0, m_keep1;
  logic s_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  int n_vec = 0, n_bad = 0, stall_viol = 0, gap_pct = 0;
  bit rand_ready = 1'b0;
  beat_t got[$], exp_q[$];
  logic [31:0] crc_tab[256];
  logic prev_stall = 1'b0;
  beat_t prev_beat;

  always #5 clk = ~clk;

  mac_tx_fcs_insert #(.DATA_WIDTH(32), .ENABLE_PAD(0), .MIN_FRAME_BYTES(60)) u_nopad (
    .i_clk(clk), .i_reset(rst),
    .i_s_axis_tdata(s_data), .i_s_axis_tkeep(s_keep),
    .i_s_axis_tvalid(s_valid & ~sel), .i_s_axis_tlast(s_last),
    .o_s_axis_tready(s_ready0),
    .o_m_axis_tdata(m_data0), .o_m_axis_tkeep(m_keep0),
    .o_m_axis_tvalid(m_valid0), .o_m_axis_tlast(m_last0),
    .i_m_axis_tready(m_tready));

  mac_tx_fcs_insert #(.DATA_WIDTH(32), .ENABLE_PAD(1), .MIN_FRAME_BYTES(60)) u_pad (
    .i_clk(clk), .i_reset(rst),
    .i_s_axis_tdata(s_data), .i_s_axis_tkeep(s_keep),
    .i_s_axis_tvalid(s_valid & sel), .i_s_axis_tlast(s_last),
    .o_s_axis_tready(s_ready1),
    .o_m_axis_tdata(m_data1), .o_m_axis_tkeep(m_keep1),
    .o_m_axis_tvalid(m_valid1), .o_m_axis_tlast(m_last1),
    .i_m_axis_tready(m_tready));

  assign s_ready = sel ? s_ready1 : s_ready0;
  assign m_valid = sel ? m_valid1 : m_valid0;
  assign m_last  = sel ? m_last1  : m_last0;
  assign m_data  = sel ? m_data1  : m_data0;
  assign m_keep  = sel ? m_keep1  : m_keep0;

  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output monitor: collects accepted beats and flags any change while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || {m_data, m_keep, m_last} !== prev_beat)) stall_viol++;
      prev_stall = m_valid && !m_tready;
      prev_beat  = {m_data, m_keep, m_last};
      if (m_valid && m_tready) got.push_back(beat_t'({m_data, m_keep, m_last}));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{k[j]}};
    return m;
  endfunction

  function automatic logic [31:0] model_fcs(input bq_t fr);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fr[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ fr[i]];
    return ~c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frame(output bq_t fr, input int len);
    fr = {};
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
  endtask

  // Wire image: data, zero pad to 60 if enabled, FCS LSB first, chunked into words.
  task automatic expect_frame(input bq_t fr, input bit pad);
    bq_t w;
    logic [31:0] f;
    beat_t bt;
    int nb, rem;
    w = fr;
    if (pad) while (w.size() < 60) w.push_back(8'h00);
    f = model_fcs(w);
    for (int i = 0; i < 4; i++) w.push_back(f[8*i +: 8]);
    nb = (w.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      bt  = '0;
      rem = w.size() - 4*b;
      if (rem > 4) rem = 4;
      for (int j = 0; j < rem; j++) bt.data[8*j +: 8] = w[4*b + j];
      bt.keep = 4'((1 << rem) - 1);
      bt.last = (b == nb - 1);
      exp_q.push_back(bt);
    end
  endtask

  task automatic send_frame(input bq_t fr, input int max_beats, output bit to,
                            output int first_wait);
    int nb, rem, budget;
    bit acc;
    nb = (fr.size() + 3) / 4;
    to = 1'b0;
    first_wait = 0;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick();
      s_data = $urandom;
      for (int j = 0; j < 4; j++)
        if (4*b + j < fr.size()) s_data[8*j +: 8] = fr[4*b + j];
      s_last = (b == nb - 1);
      if (s_last) begin
        rem    = fr.size() - 4*b;
        s_keep = 4'(1 << (rem - 1)) | (4'($urandom) & 4'((1 << (rem - 1)) - 1));
        if (rem == 4 && $urandom_range(0, 3) == 0) s_keep = 4'b0000;
      end else begin
        s_keep = 4'($urandom);
      end
      s_valid = 1'b1;
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_ready;
        if (!acc && b == 0) first_wait++;
        tick();
        budget++;
        if (budget > 2000) begin to = 1'b1; break; end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (to) break;
    end
  endtask

  task automatic wait_out(output bit to);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < 20000) begin tick(); n++; end
    to = (got.size() < exp_q.size());
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if ({s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1});
    end
    n_vec++;
    if ({m_data0, m_data1, m_keep0, m_keep1} !== 72'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h %h required zeros", m_data0, m_data1, m_keep0, m_keep1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({s_ready0, s_ready1} !== 2'b00) begin
      n_bad++;
      $display("FAIL ready_before_edge: got %b required 00", {s_ready0, s_ready1});
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({s_ready0, s_ready1} !== 2'b11) begin
      n_bad++;
      $display("FAIL ready_after_edge: got %b required 11", {s_ready0, s_ready1});
    end
    tick();
    $display("reset: done");
  endtask

  task automatic test_crc_string();
    bq_t fr;
    bit to;
    int fw;
    sel = 1'b0; got.delete(); exp_q.delete();
    fr = {};
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    exp_q.push_back({32'h34333231, 4'b1111, 1'b0});
    exp_q.push_back({32'h38373635, 4'b1111, 1'b0});
    exp_q.push_back({32'hF4392639, 4'b1111, 1'b0});
    exp_q.push_back({32'h000000CB, 4'b0001, 1'b1});
    send_frame(fr, 1 << 30, to, fw);
    wait_out(to);
    n_vec++;
    if (to || got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL crc_string beats: got %0d required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if ({got[i].data & kmask(exp_q[i].keep), got[i].keep, got[i].last} !== exp_q[i]) begin
        n_bad++;
        $display("FAIL crc_string beat %0d: got %h/%b/%b required %h/%b/%b", i,
                 got[i].data, got[i].keep, got[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    $display("crc_string: 9 bytes, %0d beats out", got.size());
  endtask

  task automatic test_model_frame(input string name, input bit pad, input int len);
    bq_t fr;
    bit to;
    int fw;
    sel = pad; got.delete(); exp_q.delete();
    rand_frame(fr, len);
    expect_frame(fr, pad);
    send_frame(fr, 1 << 30, to, fw);
    wait_out(to);
    n_vec++;
    if (to || got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s beats: got %0d required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if ({got[i].data & kmask(exp_q[i].keep), got[i].keep, got[i].last} !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s beat %0d: got %h/%b/%b required %h/%b/%b", name, i,
                 got[i].data, got[i].keep, got[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    $display("%s: pad=%0d len=%0d beats out %0d", name, pad, len, got.size());
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    gap_pct = 30;
    stall_viol = 0;
    for (int f = 0; f < 6; f++)
      test_model_frame("random", f[0], $urandom_range(4, 1500));
    for (int f = 0; f < 3; f++)
      test_model_frame("random_short", f[0], $urandom_range(4, 64));
    n_vec++;
    if (stall_viol !== 0) begin
      n_bad++;
      $display("FAIL stall_stability: got %0d changes required 0", stall_viol);
    end
    rand_ready = 1'b0;
    gap_pct = 0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    bq_t fr;
    bit to;
    int fw;
    sel = 1'b1; got.delete(); exp_q.delete();
    rand_frame(fr, 64);
    send_frame(fr, 5, to, fw);
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if ({m_valid1, m_last1, s_ready1} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b required 000", {m_valid1, m_last1, s_ready1});
    end
    tick();
    rst = 1'b0;
    got.delete();
    repeat (6) tick();
    n_vec++;
    if (got.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid_stale: got %0d beats required 0", got.size());
    end
    test_model_frame("reset_new_frame", 1'b1, 64);
  endtask

  task automatic test_back_to_back();
    bq_t fr;
    bit to;
    int fw, expw;
    int lens[4];
    for (int d = 0; d < 2; d++) begin
      sel = (d == 1); got.delete(); exp_q.delete();
      for (int f = 0; f < 4; f++) begin
        if (d == 1) lens[f] = $urandom_range(0, 1) ? $urandom_range(53, 56) : $urandom_range(60, 90);
        else        lens[f] = $urandom_range(4, 90);
        rand_frame(fr, lens[f]);
        expect_frame(fr, d == 1);
        send_frame(fr, 1 << 30, to, fw);
        if (f > 0) begin
          expw = (d == 1 && lens[f-1] < 60) ? 2 : 1;
          n_vec++;
          if (to || fw != expw) begin
            n_bad++;
            $display("FAIL b2b_gap pad=%0d frame %0d: got %0d low cycles required %0d", d, f, fw, expw);
          end
        end
      end
      wait_out(to);
      n_vec++;
      if (to || got.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL b2b beats pad=%0d: got %0d required %0d", d, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        n_vec++;
        if ({got[i].data & kmask(exp_q[i].keep), got[i].keep, got[i].last} !== exp_q[i]) begin
          n_bad++;
          $display("FAIL b2b beat %0d pad=%0d: got %h/%b/%b required %h/%b/%b", i, d,
                   got[i].data, got[i].keep, got[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        end
      end
      $display("back_to_back: pad=%0d lens %0d %0d %0d %0d", d, lens[0], lens[1], lens[2], lens[3]);
    end
  endtask

  initial begin
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
    #1;
    test_reset();
    test_crc_string();
    test_model_frame("k4_nopad", 1'b0, 8);
    test_model_frame("pad9", 1'b1, 9);
    test_random();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
